// File: rtl/serv_ram32_wide_if.sv
// serv_ram32_wide_if
//   Adapter between a SERV register file of width rf_width (8/16/32) and a
//   single-port 32-bit RAM macro with byte write enables. Narrow writes are
//   packed into one word in an accumulator, then handed to a one-entry
//   pending slot that drains into RAM whenever no read fetch needs the port.
//   Reads fetch whole words into a local buffer and later chunks are served
//   from that buffer. Fetched data is overlaid with pending and accumulator
//   bytes so that un-flushed writes are visible.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_rf_waddr/wdata  RF write address (word|chunk) and data, i_rf_wen strobe
//   i_rf_raddr        RF read address, i_rf_ren strobe
//   o_rf_rdata        read data, valid the cycle after i_rf_ren, held otherwise
//   o_ram_*           RAM word address, write data, byte enables, enable
//   i_ram_dout        RAM read data, one cycle after an enabled read
//   o_busy            accumulator or pending slot holds un-flushed data
//   o_overflow        sticky: a word was dropped because pending was full
module serv_ram32_wide_if #(
  parameter int rf_width = 8,
  parameter int regs = 32,
  localparam int cpw = 32 / rf_width,
  localparam int rf_l2d = $clog2(regs * cpw),
  localparam int ram_aw = $clog2(regs)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [rf_l2d-1:0]   i_rf_waddr,
  input  logic [rf_width-1:0] i_rf_wdata,
  input  logic                i_rf_wen,
  input  logic [rf_l2d-1:0]   i_rf_raddr,
  input  logic                i_rf_ren,
  output logic [rf_width-1:0] o_rf_rdata,
  output logic [ram_aw-1:0]   o_ram_addr,
  output logic [31:0]         o_ram_din,
  output logic [3:0]          o_ram_we,
  output logic                o_ram_en,
  input  logic [31:0]         i_ram_dout,
  output logic                o_busy,
  output logic                o_overflow
);

  localparam int unsigned cpw_u  = cpw;
  localparam int unsigned regs_u = regs;
  localparam int unsigned rfw_u  = rf_width;
  localparam int unsigned bpc_u  = rf_width / 8;
  localparam logic [1:0]  last_chunk = 2'(cpw - 1);

  function automatic logic [ram_aw-1:0] word_of(input logic [rf_l2d-1:0] a);
    return ram_aw'((32'(a) / cpw_u) % regs_u);
  endfunction

  function automatic logic [1:0] chunk_of(input logic [rf_l2d-1:0] a);
    return 2'(32'(a) % cpw_u);
  endfunction

  function automatic logic [3:0] chunk_mask(input logic [1:0] c);
    return 4'(((32'd1 << bpc_u) - 32'd1) << (32'(c) * bpc_u));
  endfunction

  function automatic logic [31:0] byte_bits(input logic [3:0] m);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = {8{m[i]}};
    return res;
  endfunction

  function automatic logic [rf_width-1:0] chunk_sel(input logic [31:0] w, input logic [1:0] c);
    return rf_width'(w >> (32'(c) * rfw_u));
  endfunction

  logic              acc_valid, acc_valid_n;
  logic [ram_aw-1:0] acc_tag, acc_tag_n;
  logic [31:0]       acc_data, acc_data_n;
  logic [3:0]        acc_mask, acc_mask_n;

  logic              pend_valid;
  logic [ram_aw-1:0] pend_tag;
  logic [31:0]       pend_data;
  logic [3:0]        pend_mask;
  logic              overflow_q;

  logic              rb_valid;
  logic [ram_aw-1:0] rb_tag;
  logic [31:0]       rb_data;
  logic              rd_pend;
  logic [ram_aw-1:0] rd_word_q;
  logic [1:0]        rd_chunk_q;
  logic [rf_width-1:0] rdata_q;

  logic [ram_aw-1:0] w_word, r_word;
  logic [1:0]        w_chunk, r_chunk;
  logic [3:0]        w_mask;
  logic [31:0]       w_bits, w_shift;
  logic              acc_hit;
  logic [31:0]       m_data;
  logic [3:0]        m_mask;

  logic              move_req;
  logic [ram_aw-1:0] move_tag;
  logic [31:0]       move_data;
  logic [3:0]        move_mask;

  logic              fetch, drain, pend_accept;
  logic              buf_valid_eff;
  logic [ram_aw-1:0] buf_tag_eff;
  logic [31:0]       buf_data_eff;
  logic [31:0]       merged_pend, merged;
  logic [rf_width-1:0] merged_chunk;

  assign w_word  = word_of(i_rf_waddr);
  assign w_chunk = chunk_of(i_rf_waddr);
  assign r_word  = word_of(i_rf_raddr);
  assign r_chunk = chunk_of(i_rf_raddr);
  assign w_mask  = chunk_mask(w_chunk);
  assign w_bits  = byte_bits(w_mask);
  assign w_shift = 32'(i_rf_wdata) << (32'(w_chunk) * rfw_u);

  // Chunk merged into the accumulator when it belongs to the same word,
  // otherwise it starts from an empty word.
  assign acc_hit = acc_valid && (acc_tag == w_word);
  assign m_data  = ((acc_hit ? acc_data : 32'd0) & ~w_bits) | w_shift;
  assign m_mask  = (acc_hit ? acc_mask : 4'd0) | w_mask;

  always_comb begin
    move_req    = 1'b0;
    move_tag    = acc_tag;
    move_data   = acc_data;
    move_mask   = acc_mask;
    acc_valid_n = acc_valid;
    acc_tag_n   = acc_tag;
    acc_data_n  = acc_data;
    acc_mask_n  = acc_mask;
    if (i_rf_wen) begin
      if (acc_valid && !acc_hit) begin
        move_req    = 1'b1;
        acc_valid_n = 1'b1;
        acc_tag_n   = w_word;
        acc_data_n  = w_shift;
        acc_mask_n  = w_mask;
      end else if (w_chunk == last_chunk) begin
        move_req    = 1'b1;
        move_tag    = w_word;
        move_data   = m_data;
        move_mask   = m_mask;
        acc_valid_n = 1'b0;
      end else begin
        acc_valid_n = 1'b1;
        acc_tag_n   = w_word;
        acc_data_n  = m_data;
        acc_mask_n  = m_mask;
      end
    end
  end

  // While a fetched word is in flight the buffer is treated as already
  // holding it, so the chunks following a fetch do not fetch again.
  assign buf_valid_eff = rd_pend ? 1'b1 : rb_valid;
  assign buf_tag_eff   = rd_pend ? rd_word_q : rb_tag;

  // A same-cycle write to the word being read would not reach the buffer,
  // so such a read fetches to pick the write up through the bypass.
  assign fetch = i_rf_ren && ((r_chunk == 2'd0) || !buf_valid_eff ||
                 (buf_tag_eff != r_word) || (i_rf_wen && (w_word == r_word)));
  assign drain       = pend_valid && !fetch;
  assign pend_accept = !pend_valid || drain;

  // Bypass priority: accumulator over pending over RAM.
  assign merged_pend = (pend_valid && (pend_tag == rd_word_q))
                       ? ((i_ram_dout & ~byte_bits(pend_mask)) | (pend_data & byte_bits(pend_mask)))
                       : i_ram_dout;
  assign merged = (acc_valid && (acc_tag == rd_word_q))
                  ? ((merged_pend & ~byte_bits(acc_mask)) | (acc_data & byte_bits(acc_mask)))
                  : merged_pend;
  assign merged_chunk = chunk_sel(merged, rd_chunk_q);
  assign buf_data_eff = rd_pend ? merged : rb_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_valid  <= 1'b0;
      acc_tag    <= '0;
      acc_data   <= '0;
      acc_mask   <= '0;
      pend_valid <= 1'b0;
      pend_tag   <= '0;
      pend_data  <= '0;
      pend_mask  <= '0;
      overflow_q <= 1'b0;
      rb_valid   <= 1'b0;
      rb_tag     <= '0;
      rb_data    <= '0;
      rd_pend    <= 1'b0;
      rd_word_q  <= '0;
      rd_chunk_q <= '0;
      rdata_q    <= '0;
    end else begin
      acc_valid <= acc_valid_n;
      acc_tag   <= acc_tag_n;
      acc_data  <= acc_data_n;
      acc_mask  <= acc_mask_n;

      if (move_req) begin
        if (pend_accept) begin
          pend_valid <= 1'b1;
          pend_tag   <= move_tag;
          pend_data  <= move_data;
          pend_mask  <= move_mask;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (drain) begin
        pend_valid <= 1'b0;
      end

      rd_pend <= fetch;
      if (fetch) begin
        rd_word_q  <= r_word;
        rd_chunk_q <= r_chunk;
      end

      if (rd_pend) begin
        rb_data  <= merged;
        rb_tag   <= rd_word_q;
        rb_valid <= !(i_rf_wen && (w_word == rd_word_q));
      end else if (i_rf_wen && (w_word == rb_tag)) begin
        rb_valid <= 1'b0;
      end

      if (i_rf_ren && !fetch) rdata_q <= chunk_sel(buf_data_eff, r_chunk);
      else if (rd_pend)       rdata_q <= merged_chunk;
    end
  end

  // Outputs are forced low while reset is held so nothing reaches the RAM
  // from state that is about to be discarded.
  always_comb begin
    o_ram_en   = 1'b0;
    o_ram_addr = '0;
    o_ram_din  = '0;
    o_ram_we   = '0;
    if (!i_rst) begin
      if (fetch) begin
        o_ram_en   = 1'b1;
        o_ram_addr = r_word;
      end else if (drain) begin
        o_ram_en   = 1'b1;
        o_ram_addr = pend_tag;
        o_ram_din  = pend_data;
        o_ram_we   = pend_mask;
      end
    end
  end

  assign o_rf_rdata = i_rst ? '0 : (rd_pend ? merged_chunk : rdata_q);
  assign o_busy     = !i_rst && (acc_valid || pend_valid);
  assign o_overflow = !i_rst && overflow_q;

endmodule

// File: tb/tb_serv_ram32_wide_if.sv
module tb_serv_ram32_wide_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  waddr, raddr;
  logic [7:0]  wdata;
  logic        wen, ren;
  logic [7:0]  rdata;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic [3:0]  ram_we;
  logic        ram_en, busy, overflow;

  int errors = 0;
  int checks = 0;
  int ram_wr_cnt = 0;
  logic wrote9 = 1'b0;
  logic [31:0] mem [32];

  serv_ram32_wide_if #(.rf_width(8), .regs(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rf_waddr(waddr), .i_rf_wdata(wdata), .i_rf_wen(wen),
    .i_rf_raddr(raddr), .i_rf_ren(ren), .o_rf_rdata(rdata),
    .o_ram_addr(ram_addr), .o_ram_din(ram_din), .o_ram_we(ram_we),
    .o_ram_en(ram_en), .i_ram_dout(ram_dout),
    .o_busy(busy), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  // RAM macro model: byte-enable writes, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we != 4'd0) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_wr_cnt <= ram_wr_cnt + 1;
        if (ram_addr == 5'd9) wrote9 <= 1'b1;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [6:0] wa, input logic [7:0] wd,
                       input logic r, input logic [6:0] ra);
    wen = w; waddr = wa; wdata = wd; ren = r; raddr = ra;
  endtask

  task automatic idle;
    drive(1'b0, 7'd0, 8'd0, 1'b0, 7'd0);
  endtask

  task automatic check_ram(input string tag, input logic en, input logic [4:0] a,
                           input logic [31:0] d, input logic [3:0] we);
    check({tag, "_en"}, 32'(ram_en), 32'(en));
    check({tag, "_addr"}, 32'(ram_addr), 32'(a));
    check({tag, "_din"}, ram_din, d);
    check({tag, "_we"}, 32'(ram_we), 32'(we));
  endtask

  task automatic check_all_zero(input string tag);
    check_ram(tag, 1'b0, 5'd0, 32'd0, 4'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int wr_base;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    ram_dout = 32'd0;
    rst = 1'b1;
    idle();
    tick(); tick();
    mid();
    check_all_zero("reset");
    tick();
    rst = 1'b0;

    // 1: four byte writes to word 5 flush as one full-word RAM write
    wr_base = ram_wr_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'(20 + i), 8'(8'h11 * (i + 1)), 1'b0, 7'd0);
      mid();
      check("t1_no_early_wr", 32'(ram_en), 32'd0);
      tick();
    end
    idle();
    mid();
    check_ram("t1_flush", 1'b1, 5'd5, 32'h44332211, 4'hf);
    check("t1_busy_flush", 32'(busy), 32'd1);
    tick();
    mid();
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_en_after", 32'(ram_en), 32'd0);
    check("t1_wr_count", 32'(ram_wr_cnt - wr_base), 32'd1);
    tick();

    // 2: partial word 3 flushed by a write to word 4
    drive(1'b1, 7'd12, 8'hAA, 1'b0, 7'd0); tick();
    drive(1'b1, 7'd13, 8'hBB, 1'b0, 7'd0); tick();
    drive(1'b1, 7'd16, 8'hCC, 1'b0, 7'd0); tick();
    idle();
    mid();
    check("t2_en", 32'(ram_en), 32'd1);
    check("t2_addr", 32'(ram_addr), 32'd3);
    check("t2_we", 32'(ram_we), 32'h3);
    check("t2_din_lo", 32'(ram_din[15:0]), 32'hBBAA);
    tick();
    mid();
    check("t2_busy_acc", 32'(busy), 32'd1);
    tick();
    drive(1'b0, 7'd0, 8'd0, 1'b1, 7'd16);
    mid();
    check_ram("t2_fetch", 1'b1, 5'd4, 32'd0, 4'd0);
    tick();
    drive(1'b0, 7'd0, 8'd0, 1'b1, 7'd17);
    mid();
    check("t2_rd16_bypass", 32'(rdata), 32'hCC);
    tick();
    idle();
    mid();
    check("t2_rd17", 32'(rdata), 32'h00);
    tick();
    drive(1'b1, 7'd17, 8'hDD, 1'b0, 7'd0); tick();
    drive(1'b1, 7'd18, 8'hEE, 1'b0, 7'd0); tick();
    drive(1'b1, 7'd19, 8'hFF, 1'b0, 7'd0); tick();
    idle();
    mid();
    check_ram("t2_word4", 1'b1, 5'd4, 32'hFFEEDDCC, 4'hf);
    tick(); tick();

    // 3: read word 7 on the cycle its last chunk is written
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'(28 + i), 8'(8'h11 * (i + 1)), i == 3, 7'd28);
      if (i == 3) begin
        mid();
        check_ram("t3_fetch", 1'b1, 5'd7, 32'd0, 4'd0);
      end
      tick();
    end
    drive(1'b0, 7'd0, 8'd0, 1'b1, 7'd29);
    mid();
    check("t3_rd28", 32'(rdata), 32'h11);
    tick();
    drive(1'b0, 7'd0, 8'd0, 1'b1, 7'd30);
    mid();
    check("t3_rd29", 32'(rdata), 32'h22);
    tick();
    drive(1'b0, 7'd0, 8'd0, 1'b1, 7'd31);
    mid();
    check("t3_rd30", 32'(rdata), 32'h33);
    tick();
    idle();
    mid();
    check("t3_rd31", 32'(rdata), 32'h44);
    tick();
    mid();
    check("t3_hold", 32'(rdata), 32'h44);
    check("t3_mem7", mem[7], 32'h44332211);
    tick();

    // 4: flush due in the same cycle as a fetch of word 2
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'(4 + i), 8'(i + 1), 1'b0, 7'd0);
      tick();
    end
    drive(1'b0, 7'd0, 8'd0, 1'b1, 7'd8);
    mid();
    check_ram("t4_fetch_first", 1'b1, 5'd2, 32'd0, 4'd0);
    check("t4_busy_fetch", 32'(busy), 32'd1);
    check("t4_ovf_fetch", 32'(overflow), 32'd0);
    tick();
    idle();
    mid();
    check_ram("t4_write_next", 1'b1, 5'd1, 32'h04030201, 4'hf);
    check("t4_busy_write", 32'(busy), 32'd1);
    tick();
    mid();
    check("t4_busy_done", 32'(busy), 32'd0);
    check("t4_ovf_done", 32'(overflow), 32'd0);
    tick();

    // 5: continuous fetches starve the pending slot
    wr_base = ram_wr_cnt;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 7'(40 + i), 8'(i + 1), 1'b1, 7'd0);
      mid();
      if (i == 5) check("t5_fetch_only_we", 32'(ram_we), 32'd0);
      if (i == 7) check("t5_ovf_before", 32'(overflow), 32'd0);
      if (i == 8) check("t5_ovf_set", 32'(overflow), 32'd1);
      tick();
    end
    idle();
    mid();
    check_ram("t5_drain", 1'b1, 5'd10, 32'h04030201, 4'hf);
    tick();
    for (int i = 0; i < 5; i++) tick();
    mid();
    check("t5_busy_idle", 32'(busy), 32'd0);
    check("t5_ovf_sticky", 32'(overflow), 32'd1);
    check("t5_wr_count", 32'(ram_wr_cnt - wr_base), 32'd1);
    tick();

    // 6: reset in the middle of word 9 discards it
    drive(1'b1, 7'd36, 8'h91, 1'b0, 7'd0); tick();
    drive(1'b1, 7'd37, 8'h92, 1'b0, 7'd0); tick();
    rst = 1'b1;
    drive(1'b1, 7'd38, 8'h93, 1'b1, 7'd36);
    mid();
    check_all_zero("t6_rst_c0");
    tick();
    mid();
    check_all_zero("t6_rst_c1");
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 6; i++) begin
      mid();
      if (i == 5) check_all_zero("t6_after");
      tick();
    end
    check("t6_no_word9", 32'(wrote9), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
